// File: rtl/svc_rv_mmio_stream.sv
// MMIO byte-stream peripheral: TX/RX byte FIFOs behind the io_* bus.
// Define SVC_RV_MMIO_STREAM_CYCLES_EN to add a free-running cycle counter at index 3.
module svc_rv_mmio_stream #(
  parameter int AW       = 10,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_ren,
  input  logic [31:0] io_raddr,
  output logic [31:0] io_rdata,
  input  logic        io_wen,
  input  logic [31:0] io_waddr,
  input  logic [31:0] io_wdata,
  input  logic [3:0]  io_wstrb,
  output logic        utx_valid,
  output logic [7:0]  utx_data,
  input  logic        utx_ready,
  input  logic        urx_valid,
  input  logic [7:0]  urx_data,
  output logic        urx_ready
);

  localparam int TXW = $clog2(TX_DEPTH);
  localparam int RXW = $clog2(RX_DEPTH);
  localparam int IW  = AW - 2;

  localparam logic [IW-1:0] IDX_TX = IW'(0);
  localparam logic [IW-1:0] IDX_ST = IW'(1);
  localparam logic [IW-1:0] IDX_RX = IW'(2);
  localparam logic [IW-1:0] IDX_CY = IW'(3);

  localparam logic [TXW:0] TX_FULL = (TXW+1)'(TX_DEPTH);
  localparam logic [RXW:0] RX_FULL = (RXW+1)'(RX_DEPTH);

  logic [IW-1:0] ridx;
  logic [IW-1:0] widx;
  assign ridx = io_raddr[AW-1:2];
  assign widx = io_waddr[AW-1:2];

  logic [7:0]   tx_mem [TX_DEPTH];
  logic [TXW-1:0] tx_wp;
  logic [TXW-1:0] tx_rp;
  logic [TXW:0]   tx_cnt;
  logic           tx_drop;

  logic [7:0]   rx_mem [RX_DEPTH];
  logic [RXW-1:0] rx_wp;
  logic [RXW-1:0] rx_rp;
  logic [RXW:0]   rx_cnt;

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_wr, tx_push, tx_pop, drop_clr;
  logic rx_push, rx_pop;

  assign tx_full  = tx_cnt == TX_FULL;
  assign tx_empty = tx_cnt == '0;
  assign rx_full  = rx_cnt == RX_FULL;
  assign rx_empty = rx_cnt == '0;

  // Full check uses the pre-pop count: a same-cycle pop never makes room
  assign tx_wr    = io_wen && widx == IDX_TX && io_wstrb[0];
  assign tx_push  = tx_wr && !tx_full;
  assign tx_pop   = !tx_empty && utx_ready;
  assign drop_clr = io_wen && widx == IDX_ST && io_wstrb[0] && io_wdata[3];

  assign rx_push  = urx_valid && !rx_full;
  assign rx_pop   = io_ren && ridx == IDX_RX && !rx_empty;

  assign utx_valid = !tx_empty;
  assign utx_data  = tx_mem[tx_rp];
  assign urx_ready = !rx_full;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= io_wdata[7:0];
    if (rx_push) rx_mem[rx_wp] <= urx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wp   <= '0;
      tx_rp   <= '0;
      tx_cnt  <= '0;
      tx_drop <= 1'b0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + TXW'(1);
      if (tx_pop)  tx_rp <= tx_rp + TXW'(1);
      unique case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + (TXW+1)'(1);
        2'b01:   tx_cnt <= tx_cnt - (TXW+1)'(1);
        default: tx_cnt <= tx_cnt;
      endcase
      if (tx_wr && tx_full) tx_drop <= 1'b1;
      else if (drop_clr)    tx_drop <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + RXW'(1);
      if (rx_pop)  rx_rp <= rx_rp + RXW'(1);
      unique case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + (RXW+1)'(1);
        2'b01:   rx_cnt <= rx_cnt - (RXW+1)'(1);
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  logic [31:0] cyc_val;
`ifdef SVC_RV_MMIO_STREAM_CYCLES_EN
  logic [31:0] cycles;
  always_ff @(posedge clk) begin
    if (rst) cycles <= '0;
    else     cycles <= cycles + 32'd1;
  end
  assign cyc_val = cycles;
`else
  assign cyc_val = '0;
`endif

  logic [31:0] rd_nxt;
  always_comb begin
    rd_nxt = '0;
    unique case (1'b1)
      ridx == IDX_ST:
        rd_nxt = {28'b0, tx_drop, !rx_empty, tx_empty, tx_full};
      ridx == IDX_RX:
        rd_nxt = rx_empty ? 32'h8000_0000 : {24'b0, rx_mem[rx_rp]};
      ridx == IDX_CY:
        rd_nxt = cyc_val;
      default:
        rd_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)         io_rdata <= '0;
    else if (io_ren) io_rdata <= rd_nxt;
  end

  logic unused_bits;
  assign unused_bits = ^{io_raddr[31:AW], io_raddr[1:0],
                         io_waddr[31:AW], io_waddr[1:0],
                         io_wdata[31:8], io_wstrb[3:1]};

endmodule

// File: tb/tb_svc_rv_mmio_stream.sv
// Self-checking bench for svc_rv_mmio_stream.
// Queue-based reference model plus directed and random stimulus.
module tb_svc_rv_mmio_stream;

  localparam int AW  = 10;
  localparam int TXD = 16;
  localparam int RXD = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        io_ren;
  logic [31:0] io_raddr;
  logic [31:0] io_rdata;
  logic        io_wen;
  logic [31:0] io_waddr;
  logic [31:0] io_wdata;
  logic [3:0]  io_wstrb;
  logic        utx_valid;
  logic [7:0]  utx_data;
  logic        utx_ready;
  logic        urx_valid;
  logic [7:0]  urx_data;
  logic        urx_ready;

  svc_rv_mmio_stream #(
    .AW(AW), .TX_DEPTH(TXD), .RX_DEPTH(RXD)
  ) dut (
    .clk(clk), .rst(rst),
    .io_ren(io_ren), .io_raddr(io_raddr), .io_rdata(io_rdata),
    .io_wen(io_wen), .io_waddr(io_waddr),
    .io_wdata(io_wdata), .io_wstrb(io_wstrb),
    .utx_valid(utx_valid), .utx_data(utx_data),
    .utx_ready(utx_ready),
    .urx_valid(urx_valid), .urx_data(urx_data),
    .urx_ready(urx_ready)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0]  txq[$];
  logic [7:0]  rxq[$];
  bit          drop;
  logic [31:0] exp_rd;
  logic [31:0] cyc_m;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] addr_of(input int idx);
    logic [31:0] a;
    a = $urandom;
    a[AW-1:2] = (AW-2)'(idx);
    return a;
  endfunction

  // One clock: check stream outputs, predict, clock, update model, check read data
  task automatic step();
    int ri, wi;
    bit tpop, twr, tfull, clr, rpop, rpush, r;
    logic [7:0] wd, rd8;
    logic [31:0] e;
    chk("utx_valid", 32'(utx_valid), 32'(txq.size() != 0));
    if (txq.size() != 0)
      chk("utx_data", 32'(utx_data), 32'(txq[0]));
    chk("urx_ready", 32'(urx_ready), 32'(rxq.size() < RXD));
    ri    = int'(io_raddr[AW-1:2]);
    wi    = int'(io_waddr[AW-1:2]);
    wd    = io_wdata[7:0];
    rd8   = urx_data;
    r     = rst;
    tpop  = utx_ready && txq.size() != 0;
    twr   = io_wen && wi == 0 && io_wstrb[0];
    tfull = txq.size() == TXD;
    clr   = io_wen && wi == 1 && io_wstrb[0] && io_wdata[3];
    rpop  = io_ren && ri == 2 && rxq.size() != 0;
    rpush = urx_valid && rxq.size() < RXD;
    if (io_ren) begin
      case (ri)
        1: e = {28'b0, drop, rxq.size() != 0,
                txq.size() == 0, txq.size() == TXD};
        2: e = (rxq.size() != 0) ? {24'b0, rxq[0]} : 32'h8000_0000;
`ifdef SVC_RV_MMIO_STREAM_CYCLES_EN
        3: e = cyc_m;
`endif
        default: e = 32'h0;
      endcase
      exp_rd = e;
    end
    @(posedge clk);
    #1;
    if (r) begin
      txq.delete();
      rxq.delete();
      drop   = 0;
      exp_rd = 0;
      cyc_m  = 0;
    end else begin
      if (tpop) void'(txq.pop_front());
      if (twr) begin
        if (tfull) drop = 1;
        else       txq.push_back(wd);
      end
      if (clr) drop = 0;
      if (rpop) void'(rxq.pop_front());
      if (rpush) rxq.push_back(rd8);
      cyc_m = cyc_m + 32'd1;
    end
    chk("io_rdata", io_rdata, exp_rd);
  endtask

  task automatic rd(input int idx);
    io_ren   = 1'b1;
    io_raddr = addr_of(idx);
    step();
    io_ren   = 1'b0;
  endtask

  task automatic wr(input int idx, input logic [31:0] d,
                    input logic [3:0] s);
    io_wen   = 1'b1;
    io_waddr = addr_of(idx);
    io_wdata = d;
    io_wstrb = s;
    step();
    io_wen   = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int idx;
    rst = 1'b1;
    io_ren = 1'b0; io_raddr = '0;
    io_wen = 1'b0; io_waddr = '0; io_wdata = '0; io_wstrb = '0;
    utx_ready = 1'b0; urx_valid = 1'b0; urx_data = '0;
    repeat (2) @(posedge clk);
    #1;
    exp_rd = 0; cyc_m = 0; drop = 0;
    rst = 1'b0;
    chk("rst_rdata", io_rdata, 32'h0);
    chk("rst_utx_valid", 32'(utx_valid), 32'h0);
    chk("rst_urx_ready", 32'(urx_ready), 32'h1);
    rd(1);
    chk("status_rst", io_rdata, 32'h2);

    wr(0, 32'h48, 4'h1);
    wr(0, 32'h69, 4'h1);
    chk("hi_valid", 32'(utx_valid), 32'h1);
    chk("hi_h", 32'(utx_data), 32'h48);
    utx_ready = 1'b1;
    step();
    chk("hi_i", 32'(utx_data), 32'h69);
    step();
    chk("hi_done", 32'(utx_valid), 32'h0);
    utx_ready = 1'b0;
    wr(0, 32'h5A, 4'h2);
    chk("no_strb0", 32'(utx_valid), 32'h0);

    for (int i = 0; i < TXD + 1; i++) wr(0, 32'h30 + i, 4'h1);
    rd(1);
    chk("status_full_drop", io_rdata, 32'h9);
    wr(1, 32'h8, 4'h1);
    rd(1);
    chk("status_drop_clr", io_rdata, 32'h1);
    utx_ready = 1'b1;
    for (int i = 0; i < TXD; i++) begin
      chk("drain", 32'(utx_data), 32'h30 + i);
      step();
    end
    chk("drain_empty", 32'(utx_valid), 32'h0);
    utx_ready = 1'b0;

    urx_data = 8'hA5; urx_valid = 1'b1;
    step();
    urx_valid = 1'b0;
    rd(1);
    chk("status_rx", io_rdata, 32'h6);
    rd(2);
    chk("rx_a5", io_rdata, 32'h0000_00A5);
    rd(2);
    chk("rx_empty", io_rdata, 32'h8000_0000);

    urx_valid = 1'b1;
    for (int j = 0; j < RXD; j++) begin
      urx_data = 8'h10 + 8'(j);
      step();
    end
    chk("rx_full_ready", 32'(urx_ready), 32'h0);
    urx_data = 8'hEE;
    step();
    rd(2);
    chk("rx_full_pop", io_rdata, 32'h10);
    chk("rx_ready_again", 32'(urx_ready), 32'h1);
    urx_data = 8'hEF;
    rd(2);
    chk("rx_rd_push", io_rdata, 32'h11);
    chk("rx_cnt_same", 32'(urx_ready), 32'h1);
    urx_valid = 1'b0;
    for (int j = 0; j < RXD; j++) rd(2);
    chk("rx_drained", io_rdata, 32'h8000_0000);

    for (int k = 0; k < 600; k++) begin
      io_ren   = 1'($urandom % 2);
      idx      = (k < 300 && $urandom % 4 != 0) ? 1 : int'($urandom % 6);
      io_raddr = addr_of(idx);
      io_wen   = 1'($urandom % 2);
      idx      = ($urandom % 4 == 0) ? int'($urandom % 6) : 0;
      io_waddr = addr_of(idx);
      io_wdata = $urandom;
      io_wstrb = 4'($urandom);
      utx_ready = (k < 300) ? ($urandom % 8 == 0) : ($urandom % 4 != 0);
      urx_valid = 1'($urandom % 2);
      urx_data  = 8'($urandom);
      rst       = ($urandom % 150 == 0);
      step();
    end
    io_ren = 1'b0; io_wen = 1'b0; rst = 1'b0;
    utx_ready = 1'b0; urx_valid = 1'b0;
    step();

`ifdef SVC_RV_MMIO_STREAM_CYCLES_EN
    rd(3);
    a = io_rdata;
    repeat (4) step();
    rd(3);
    chk("cycles_delta", io_rdata - a, 32'd5);
`else
    rd(3);
    a = 32'h0;
    chk("cycles_off", io_rdata, a);
`endif

    wr(0, 32'h01, 4'h1);
    wr(0, 32'h02, 4'h1);
    urx_data = 8'h07; urx_valid = 1'b1;
    step();
    urx_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_valid", 32'(utx_valid), 32'h0);
    chk("midrst_ready", 32'(urx_ready), 32'h1);
    chk("midrst_rdata", io_rdata, 32'h0);
    rd(1);
    chk("midrst_status", io_rdata, 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
